asrv32_regfile_mp: RTL and testbench
====================================

Name: asrv32_regfile_mp

Overview:
Parametrised multi-read-port integer register file for ASRV32 cores, and the successor to the base register file.
- Width, depth and read-port count are configurable.
- Reads are truly registered, with an optional write-first bypass.
- A post-reset clear sequencer zeroes the array one entry per cycle, so the array needs no reset and maps to RAM.
- Sits between decode (read addresses) and writeback (write port); feeds the ALU operand muxes.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, 2..64. 16 gives RV32E.
- AW, $clog2(DEPTH), register address width (derived; do not override).
- NRD, 2, number of read ports, 1..4.
- ZERO_REG, 1, 1 = entry 0 is hardwired to zero; 0 = entry 0 is a normal register.
- BYPASS, 1, 1 = write-first forwarding on a same-cycle read/write collision; 0 = read-first.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_ce_rd  in  1  read enable; captures all NRD ports this cycle.
- i_rs_addr  in  NRD*AW  packed read addresses; port k at [k*AW +: AW].
- o_rs_data  out  NRD*XLEN  packed registered read data; port k at [k*XLEN +: XLEN].
- i_ce_wr  in  1  write enable.
- i_rd_addr  in  AW  write address.
- i_rd_data  in  XLEN  write data.
- o_busy  out  1  high while the clear sequence runs; writes and reads are not accepted.

Behaviour:
- Reset (asynchronous assert, i_rst_n=0):
  - o_rs_data = 0, o_busy = 1.
  - Clear FSM enters CLEAR with clr_idx = 0.
  - Array contents are not reset directly.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes 0 to array[clr_idx], then clr_idx++.
  - When clr_idx == DEPTH-1 has been written, next state is READY and o_busy falls on the following edge.
  - Duration is exactly DEPTH cycles after the first rising edge with i_rst_n=1.
  - ZERO_REG=1 may skip index 0 (DEPTH-1 cycles). The implementation must document the chosen count; the bench reads it from o_busy.
  - READY: terminal; stays in READY until the next reset.
- Reset asserted mid-CLEAR: restart from clr_idx = 0. No partial state survives.
- While o_busy=1:
  - i_ce_wr is ignored (no array write).
  - i_ce_rd is ignored; o_rs_data holds 0.
- Write (READY, i_ce_wr=1): array[i_rd_addr] <= i_rd_data on the rising edge.
  - When ZERO_REG=1 and i_rd_addr==0, the write is suppressed.
- Read (READY, i_ce_rd=1): for each port k, o_rs_data[k] <= array[addr_k] on the rising edge.
  - Latency is 1 cycle.
  - With i_ce_rd=0, o_rs_data holds its value even if the array changes underneath.
- Zero register: ZERO_REG=1 and addr_k==0 returns 0 regardless of array contents.
- Collision: i_ce_rd and i_ce_wr in the same cycle with addr_k == i_rd_addr.
  - BYPASS=1: port k captures i_rd_data (write-first).
  - BYPASS=0: port k captures the old contents (read-first).
  - The zero-register rule takes precedence over bypass.
- Multiple read ports with the same address return identical data. No port priority.
- Array storage is one write port and NRD read ports. Synthesis may replicate the RAM per read port; behaviour must be identical either way.

Decomposition:
- Package asrv32_pkg:
  - XLEN_DEFAULT = 32.
  - REG_DEPTH_RV32I = 32, REG_DEPTH_RV32E = 16.
  - Clear-FSM state encoding: CLEAR = 1'b0, READY = 1'b1.
- Sub-module asrv32_regfile_clr: clear sequencer.
  - Holds the FSM and clr_idx counter.
  - Outputs the muxed write enable, address and data (clear vs. user), plus o_busy.
- Top level holds the array, the per-port read registers and the bypass/zero muxing, using a generate loop over NRD.

Test Plan:
- Release reset, hold i_ce_wr=1 with addr 5 and data 0xDEAD_BEEF throughout CLEAR -> o_busy high for the documented cycle count; afterwards a read of x5 returns 0 (the write was ignored).
- READY: write x3=0x1234_5678, next cycle i_ce_rd with rs0=3, rs1=0 -> one cycle later o_rs_data port0=0x1234_5678, port1=0.
- Write x0=0xFFFF_FFFF then read x0 -> 0 (ZERO_REG=1). Re-run with ZERO_REG=0 -> 0xFFFF_FFFF.
- Same-cycle write x7=0xA5A5_A5A5 (old value 0x1) and read rs0=7 -> BYPASS=1 gives 0xA5A5_A5A5; BYPASS=0 gives 0x0000_0001.
- Capture x3, then with i_ce_rd=0 write x3=0x9 -> o_rs_data stays 0x1234_5678 until the next i_ce_rd.
- Pulse i_rst_n low at CLEAR cycle 10, then reassert -> o_busy restarts the full count, o_rs_data=0, all registers read 0 afterwards. NRD=4, DEPTH=16 variant: all four ports reading x15 return identical data.

Source files
------------

// File: rtl/asrv32_pkg.sv
// Shared constants and types for the ASRV32 register-file slice.
// Holds the default data width, the standard register-file depths and the clear-FSM encoding.
package asrv32_pkg;

  localparam int XLEN_DEFAULT    = 32;
  localparam int REG_DEPTH_RV32I = 32;
  localparam int REG_DEPTH_RV32E = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/asrv32_regfile_clr.sv
// Post-reset clear sequencer: walks every array entry writing zero, then hands
// the write port to the user. The sequence always covers all DEPTH entries (entry 0 included).
module asrv32_regfile_clr
  import asrv32_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int DEPTH    = REG_DEPTH_RV32I,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ce_wr,
  input  logic [AW-1:0]   i_rd_addr,
  input  logic [XLEN-1:0] i_rd_data,
  output logic            o_we,
  output logic [AW-1:0]   o_waddr,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_busy
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          user_we;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == CLEAR) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == AW'(DEPTH - 1)) state_d = READY;
    end
  end

  assign o_busy  = (state_q == CLEAR);
  // Writes to x0 are dropped here so the array never holds a non-zero entry 0.
  assign user_we = i_ce_wr && !((ZERO_REG != 0) && (i_rd_addr == '0));
  assign o_we    = o_busy || user_we;
  assign o_waddr = o_busy ? idx_q : i_rd_addr;
  assign o_wdata = o_busy ? '0 : i_rd_data;

endmodule

// File: rtl/asrv32_regfile_mp.sv
// Multi-read-port integer register file: one write port, NRD registered read ports,
// optional write-first bypass and hardwired x0. Contents are zeroed by a post-reset sequencer.
module asrv32_regfile_mp
  import asrv32_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int DEPTH    = REG_DEPTH_RV32I,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ce_rd,
  input  logic [NRD*AW-1:0]   i_rs_addr,
  output logic [NRD*XLEN-1:0] o_rs_data,
  input  logic                i_ce_wr,
  input  logic [AW-1:0]       i_rd_addr,
  input  logic [XLEN-1:0]     i_rd_data,
  output logic                o_busy
);

  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic            busy;

  asrv32_regfile_clr #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_clr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ce_wr   (i_ce_wr),
    .i_rd_addr (i_rd_addr),
    .i_rd_data (i_rd_data),
    .o_we      (we),
    .o_waddr   (waddr),
    .o_wdata   (wdata),
    .o_busy    (busy)
  );

  assign o_busy = busy;

  logic [XLEN-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM; the clear sequencer zeroes it instead.
  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] q;
    logic            hit_zero;
    logic            hit_wr;

    assign addr     = i_rs_addr[k*AW +: AW];
    assign hit_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit_wr   = (BYPASS != 0) && i_ce_wr && (i_rd_addr == addr);

    // The zero rule wins over forwarding; without forwarding the pre-edge array value is read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        q <= '0;
      end else if (i_ce_rd && !busy) begin
        if (hit_zero)    q <= '0;
        else if (hit_wr) q <= i_rd_data;
        else             q <= mem[addr];
      end
    end

    assign o_rs_data[k*XLEN +: XLEN] = q;
  end

endmodule

// File: tb/tb_asrv32_regfile_mp.sv
// Directed bench for asrv32_regfile_mp: three configurations checked against a
// scoreboard of expected read data filled as stimulus is driven.
module tb_asrv32_regfile_mp;

  logic        clk;
  logic        rst_n;

  // Configurations A (defaults) and B (ZERO_REG=0, BYPASS=0) share stimulus.
  logic        ce_rd, ce_wr;
  logic [9:0]  rs_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [63:0] rs_a, rs_b;
  logic        busy_a, busy_b;

  // Configuration C: NRD=4, DEPTH=16.
  logic         ce_rd_c, ce_wr_c;
  logic [15:0]  rs_addr_c;
  logic [3:0]   rd_addr_c;
  logic [31:0]  rd_data_c;
  logic [127:0] rs_c;
  logic         busy_c;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  asrv32_regfile_mp u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce_rd(ce_rd), .i_rs_addr(rs_addr), .o_rs_data(rs_a),
    .i_ce_wr(ce_wr), .i_rd_addr(rd_addr), .i_rd_data(rd_data), .o_busy(busy_a)
  );

  asrv32_regfile_mp #(.ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce_rd(ce_rd), .i_rs_addr(rs_addr), .o_rs_data(rs_b),
    .i_ce_wr(ce_wr), .i_rd_addr(rd_addr), .i_rd_data(rd_data), .o_busy(busy_b)
  );

  asrv32_regfile_mp #(.DEPTH(16), .NRD(4)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce_rd(ce_rd_c), .i_rs_addr(rs_addr_c), .o_rs_data(rs_c),
    .i_ce_wr(ce_wr_c), .i_rd_addr(rd_addr_c), .i_rd_data(rd_data_c), .o_busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_port(input int sel);
    case (sel)
      0:       return rs_a[31:0];
      1:       return rs_a[63:32];
      2:       return rs_b[31:0];
      3:       return rs_b[63:32];
      default: return rs_c[(sel-4)*32 +: 32];
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic expect_ab(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] b0, input logic [31:0] b1);
    push({tag, "_a0"}, 0, a0);
    push({tag, "_a1"}, 1, a1);
    push({tag, "_b0"}, 2, b0);
    push({tag, "_b1"}, 3, b1);
  endtask

  // Advance one cycle, then compare everything the scoreboard expects after that edge.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, 128'(obs_port(e.sel)), 128'(e.exp));
    end
  endtask

  // Count cycles from reset release until each o_busy falls; bounded at 64 cycles.
  task automatic run_clear(input string tag);
    int cnt_a = 0, cnt_b = 0, cnt_c = 0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      @(negedge clk);
      if (cnt_a == 0 && !busy_a) begin
        cnt_a = cyc;
        check({tag, "_rs_a_zero_in_clear"}, 128'(rs_a), 128'(0));
        check({tag, "_rs_b_zero_in_clear"}, 128'(rs_b), 128'(0));
        ce_wr = 1'b0;
        ce_rd = 1'b0;
      end
      if (cnt_b == 0 && !busy_b) cnt_b = cyc;
      if (cnt_c == 0 && !busy_c) begin
        cnt_c = cyc;
        check({tag, "_rs_c_zero_in_clear"}, 128'(rs_c), 128'(0));
        ce_wr_c = 1'b0;
        ce_rd_c = 1'b0;
      end
    end
    check({tag, "_busy_cycles_a"}, 128'(cnt_a), 128'(32));
    check({tag, "_busy_cycles_b"}, 128'(cnt_b), 128'(32));
    check({tag, "_busy_cycles_c"}, 128'(cnt_c), 128'(16));
  endtask

  initial begin
    rst_n   = 1'b1;
    ce_rd   = 1'b0; ce_wr   = 1'b0; rs_addr   = '0; rd_addr   = '0; rd_data   = '0;
    ce_rd_c = 1'b0; ce_wr_c = 1'b0; rs_addr_c = '0; rd_addr_c = '0; rd_data_c = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_busy_a", 128'(busy_a), 128'(1));
    check("reset_busy_c", 128'(busy_c), 128'(1));
    check("reset_rs_a", 128'(rs_a), 128'(0));
    check("reset_rs_c", rs_c, 128'(0));

    // Hold a write to x5 and a read throughout the clear; both must be ignored.
    ce_wr   = 1'b1; rd_addr   = 5'd5; rd_data   = 32'hDEAD_BEEF; ce_rd   = 1'b1; rs_addr = {5'd5, 5'd5};
    ce_wr_c = 1'b1; rd_addr_c = 4'd5; rd_data_c = 32'hDEAD_BEEF; ce_rd_c = 1'b1; rs_addr_c = {4{4'd5}};
    rst_n = 1'b1;
    run_clear("clr1");

    ce_rd = 1'b1; rs_addr = {5'd5, 5'd5};
    expect_ab("x5_after_clear", 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    ce_rd = 1'b0;

    ce_wr = 1'b1; rd_addr = 5'd3; rd_data = 32'h1234_5678;
    tick();
    ce_wr = 1'b0;
    ce_rd = 1'b1; rs_addr = {5'd0, 5'd3};
    expect_ab("rd_x3_x0", 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0);
    tick();
    ce_rd = 1'b0;

    // Array changes underneath a held output.
    ce_wr = 1'b1; rd_addr = 5'd3; rd_data = 32'h9;
    push("hold1_a0", 0, 32'h1234_5678);
    push("hold1_b0", 2, 32'h1234_5678);
    tick();
    ce_wr = 1'b0;
    push("hold2_a0", 0, 32'h1234_5678);
    push("hold2_b0", 2, 32'h1234_5678);
    tick();
    ce_rd = 1'b1; rs_addr = {5'd3, 5'd3};
    expect_ab("rd_x3_new", 32'h9, 32'h9, 32'h9, 32'h9);
    tick();
    ce_rd = 1'b0;

    ce_wr = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF;
    tick();
    ce_wr = 1'b0;
    ce_rd = 1'b1; rs_addr = {5'd0, 5'd0};
    expect_ab("rd_x0", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    ce_rd = 1'b0;

    ce_wr = 1'b1; rd_addr = 5'd7; rd_data = 32'h1;
    tick();
    ce_rd = 1'b1; rs_addr = {5'd7, 5'd7}; rd_data = 32'hA5A5_A5A5;
    expect_ab("collide_x7", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h1, 32'h1);
    tick();
    ce_wr = 1'b0;
    expect_ab("rd_x7_after", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    tick();

    // Zero rule beats forwarding on A; B reads the old x0 first.
    ce_wr = 1'b1; rd_addr = 5'd0; rd_data = 32'h55; rs_addr = {5'd0, 5'd0};
    expect_ab("collide_x0", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    ce_wr = 1'b0; ce_rd = 1'b0;
    check("busy_a_ready", 128'(busy_a), 128'(0));

    ce_wr_c = 1'b1; rd_addr_c = 4'd15; rd_data_c = 32'hCAFE_F00D;
    tick();
    ce_wr_c = 1'b0;
    ce_rd_c = 1'b1; rs_addr_c = {4{4'd15}};
    for (int k = 0; k < 4; k++) push($sformatf("c_x15_p%0d", k), 4 + k, 32'hCAFE_F00D);
    tick();
    ce_wr_c = 1'b1; rd_data_c = 32'h0BAD_C0DE;
    for (int k = 0; k < 4; k++) push($sformatf("c_bypass_p%0d", k), 4 + k, 32'h0BAD_C0DE);
    tick();
    ce_wr_c = 1'b0; ce_rd_c = 1'b0;

    // Leave non-zero state behind so the reset checks below can fail.
    ce_wr = 1'b1; rd_addr = 5'd20; rd_data = 32'h2020_2020;
    tick();
    ce_wr = 1'b0;
    ce_rd = 1'b1; rs_addr = {5'd3, 5'd7};
    expect_ab("rd_pre_reset", 32'hA5A5_A5A5, 32'h9, 32'hA5A5_A5A5, 32'h9);
    tick();
    ce_rd = 1'b0;

    rst_n = 1'b0;
    #1;
    check("async_rst_rs_a", 128'(rs_a), 128'(0));
    check("async_rst_busy_a", 128'(busy_a), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    ce_wr = 1'b1; rd_addr = 5'd9; rd_data = 32'h99;
    repeat (10) @(negedge clk);
    check("mid_clear_busy_a", 128'(busy_a), 128'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_rs_b", 128'(rs_b), 128'(0));
    check("mid_rst_rs_c", rs_c, 128'(0));
    @(negedge clk);
    ce_rd = 1'b1; rs_addr = {5'd20, 5'd20};
    ce_wr_c = 1'b1; rd_addr_c = 4'd15; rd_data_c = 32'h77; ce_rd_c = 1'b1; rs_addr_c = {4{4'd15}};
    rst_n = 1'b1;
    run_clear("clr2");

    ce_rd = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs_addr = {5'(31 - i), 5'(i)};
      expect_ab($sformatf("all_zero_%0d", i), 32'h0, 32'h0, 32'h0, 32'h0);
      tick();
    end
    ce_rd = 1'b0;
    ce_rd_c = 1'b1; rs_addr_c = {4{4'd15}};
    for (int k = 0; k < 4; k++) push($sformatf("c_zero_x15_p%0d", k), 4 + k, 32'h0);
    tick();
    ce_rd_c = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
